instr_mem_ctrl: RTL
===================

INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

Interface
REQ-001 SHALL have parameter IWIDTH, 32, instruction word width.
REQ-002 SHALL have parameter AWIDTH_INSTR, 32, byte-address width.
REQ-003 SHALL have parameter DEPTH, 1024, number of instruction words stored.
REQ-004 SHALL have parameter LATENCY, 2, cycles from request acceptance to ack; legal range 1..8.
REQ-005 SHALL have port im_clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port im_rst, input, 1, reset; asynchronous and active-low.
REQ-007 SHALL have port im_i_syn, input, 1, fetch request, level-sensitive.
REQ-008 SHALL have port im_i_addr, input, AWIDTH_INSTR, byte address of the requested instruction.
REQ-009 SHALL have port im_i_flush, input, 1, abort any pending request.
REQ-010 SHALL have port im_i_we, input, 1, preload write enable.
REQ-011 SHALL have port im_i_waddr, input, AWIDTH_INSTR, preload byte address.
REQ-012 SHALL have port im_i_wdata, input, IWIDTH, preload data.
REQ-013 SHALL have port im_o_instr, output, IWIDTH, returned instruction, valid while im_o_ack=1.
REQ-014 SHALL have port im_o_ack, output, 1, one-cycle response strobe.
REQ-015 SHALL have port im_o_last, output, 1, qualified by ack; tells fetch to stop streaming.
REQ-016 SHALL have port im_o_busy, output, 1, high while a request is outstanding (WAIT or RESP).
REQ-017 SHALL have port im_o_err, output, 1, qualified by ack; misaligned or out-of-range address.

Function
REQ-018 SHALL implement FSM IDLE, WAIT, RESP; all outputs registered.
REQ-019 IDLE with im_i_syn=1 and im_i_flush=0 SHALL capture im_i_addr, load the latency counter with LATENCY-1, and go to WAIT; otherwise stay in IDLE.
REQ-020 WAIT SHALL decrement the counter each cycle; when the counter is 0, it SHALL read the array and go to RESP; ack SHALL therefore be high exactly LATENCY cycles after the acceptance edge.
REQ-021 RESP SHALL drive im_o_ack=1 for exactly one cycle, then return to IDLE; im_i_syn still high in that IDLE cycle SHALL start a new request (back-to-back throughput = one word per LATENCY+1 cycles).
REQ-022 Word index SHALL be im_i_addr[AWIDTH_INSTR-1:2]; index = DEPTH-1 SHALL set im_o_last=1 with ack.
REQ-023 If addr[1:0]!=0 or index>=DEPTH, the response SHALL return im_o_instr=32'h00000013 (NOP) with im_o_err=1 and im_o_last=1.
REQ-024 im_i_flush=1 in WAIT SHALL abort to IDLE with no ack; flush in IDLE SHALL block acceptance; flush coincident with RESP SHALL NOT suppress the already-registered ack.
REQ-025 A preload write SHALL take effect at the clock edge; a write on the same edge as the WAIT->RESP array read SHALL return old data; writes to index>=DEPTH or misaligned addresses SHALL be ignored.
REQ-026 im_o_instr SHALL hold its last value when ack=0; im_o_last and im_o_err SHALL be 0 whenever ack=0.
REQ-027 im_i_addr changes after acceptance SHALL NOT affect the outstanding response.

Reset
REQ-028 im_rst=0 SHALL immediately force state IDLE, counter 0, im_o_instr=0, im_o_ack=0, im_o_last=0, im_o_busy=0, im_o_err=0.
REQ-029 Reset mid-request SHALL discard it with no ack after release; array contents SHALL NOT be reset.

Structure
REQ-030 Package instr_mem_pkg SHALL hold the FSM state encoding, the NOP constant 32'h00000013, and the LATENCY bounds.
REQ-031 Storage SHALL be the sub-module instr_mem_array: DEPTH x IWIDTH synchronous RAM with one read port and one write port, no reset.
REQ-032 Counter width SHALL be clog2(LATENCY)+1 bits, with no wrap past 0.

Verification
REQ-033 Preload words 0..3 = 0x11,0x22,0x33,0x44; LATENCY=2; syn=1, addr=0x8 -> ack high 2 cycles after acceptance, instr=0x33, last=0, err=0.
REQ-034 syn held high, addr stepping 0x0,0x4,0x8 -> three acks spaced 3 cycles apart returning 0x11,0x22,0x33.
REQ-035 DEPTH=4, addr=0xC -> ack with instr=0x44, last=1; addr=0x10 -> instr=0x13, err=1, last=1; addr=0x2 -> err=1, last=1.
REQ-036 Request at 0x4, flush 1 cycle after acceptance -> no ack, busy falls next cycle; the following request at 0x0 returns 0x11.
REQ-037 im_rst asserted during WAIT -> all outputs 0 asynchronously, no ack after release, preloaded word 0x11 still readable.
REQ-038 Write 0x99 to 0x4 on the WAIT->RESP edge of a read of 0x4 -> ack returns 0x22; the next read of 0x4 returns 0x99.

Source files
------------

// File: rtl/instr_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instr_mem_pkg
// Brief   : Shared types and constants for the instruction memory controller.
// Revision: 1.0 - initial release
// ============================================================================
package instr_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Selects what drives the instruction output between responses.
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_NOP  = 2'd2
    } src_t;

    localparam logic [31:0] c_nop         = 32'h0000_0013;
    localparam int          c_latency_min = 1;
    localparam int          c_latency_max = 8;

endpackage : instr_mem_pkg
`default_nettype wire

// File: rtl/instr_mem_array.sv
`default_nettype none
// ============================================================================
// Module  : instr_mem_array
// Brief   : DEPTH x IWIDTH synchronous RAM, one write port, one read port,
//           read-before-write on a shared address. Contents are not reset.
// Revision: 1.0 - initial release
// ============================================================================
module instr_mem_array #(
    parameter int IWIDTH = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [IWIDTH-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [IWIDTH-1:0] o_rdata
);

    logic [IWIDTH-1:0] r_mem [DEPTH];
    logic [IWIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : instr_mem_array
`default_nettype wire

// File: rtl/instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : instr_mem_ctrl
// Brief   : Fixed-latency instruction fetch controller with preload port,
//           flush abort and misaligned/out-of-range error responses.
// Revision: 1.0 - initial release
// ============================================================================
module instr_mem_ctrl
    import instr_mem_pkg::*;
#(
    parameter int IWIDTH       = 32,
    parameter int AWIDTH_INSTR = 32,
    parameter int DEPTH        = 1024,
    parameter int LATENCY      = 2
) (
    input  logic                    im_clk,
    input  logic                    im_rst,
    input  logic                    im_i_syn,
    input  logic [AWIDTH_INSTR-1:0] im_i_addr,
    input  logic                    im_i_flush,
    input  logic                    im_i_we,
    input  logic [AWIDTH_INSTR-1:0] im_i_waddr,
    input  logic [IWIDTH-1:0]       im_i_wdata,
    output logic [IWIDTH-1:0]       im_o_instr,
    output logic                    im_o_ack,
    output logic                    im_o_last,
    output logic                    im_o_busy,
    output logic                    im_o_err
);

    localparam int c_cnt_w  = $clog2(LATENCY) + 1;
    localparam int c_idx_w  = AWIDTH_INSTR - 2;
    localparam int c_ram_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(LATENCY - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_depth    = c_idx_w'(DEPTH);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DEPTH - 1);

    if (LATENCY < c_latency_min || LATENCY > c_latency_max) begin : g_latency_range
        $error("instr_mem_ctrl: LATENCY outside legal range");
    end

    state_t                  r_state, w_state_nxt;
    logic [c_cnt_w-1:0]      r_cnt, w_cnt_nxt;
    logic [AWIDTH_INSTR-1:0] r_addr, w_addr_nxt;
    src_t                    r_src, w_src_nxt;
    logic                    r_ack, w_ack_nxt;
    logic                    r_last, w_last_nxt;
    logic                    r_err, w_err_nxt;
    logic                    r_busy, w_busy_nxt;
    logic                    w_rd_en;

    logic [c_idx_w-1:0]      w_rd_idx, w_wr_idx;
    logic                    w_rd_ok, w_wr_ok;
    logic [IWIDTH-1:0]       w_rdata;

    assign w_rd_idx = r_addr[AWIDTH_INSTR-1:2];
    assign w_rd_ok  = (r_addr[1:0] == 2'b00) && (w_rd_idx < c_depth);
    assign w_wr_idx = im_i_waddr[AWIDTH_INSTR-1:2];
    assign w_wr_ok  = (im_i_waddr[1:0] == 2'b00) && (w_wr_idx < c_depth);

    instr_mem_array #(
        .IWIDTH (IWIDTH),
        .DEPTH  (DEPTH),
        .AW     (c_ram_aw)
    ) u_array (
        .clk     (im_clk),
        .i_we    (im_i_we && w_wr_ok),
        .i_waddr (w_wr_idx[c_ram_aw-1:0]),
        .i_wdata (im_i_wdata),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_idx[c_ram_aw-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge im_clk or negedge im_rst) begin
        if (!im_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_src   <= SRC_ZERO;
            r_ack   <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_src   <= w_src_nxt;
            r_ack   <= w_ack_nxt;
            r_last  <= w_last_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // RESP behaves like IDLE for acceptance so back-to-back fetches cost LATENCY+1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_src_nxt   = r_src;
        w_ack_nxt   = 1'b0;
        w_last_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_rd_en     = 1'b0;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (im_i_syn && !im_i_flush) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = c_cnt_load;
                    w_addr_nxt  = im_i_addr;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (im_i_flush) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                    w_ack_nxt   = 1'b1;
                    w_rd_en     = w_rd_ok;
                    w_err_nxt   = !w_rd_ok;
                    w_last_nxt  = !w_rd_ok || (w_rd_idx == c_last_idx);
                    w_src_nxt   = w_rd_ok ? SRC_RAM : SRC_NOP;
                end else begin
                    w_cnt_nxt   = r_cnt - c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // RAM read data only changes on a response edge, so this select holds
    // the last returned word between acks without a second data register.
    assign im_o_instr = (r_src == SRC_RAM) ? w_rdata :
                        (r_src == SRC_NOP) ? IWIDTH'(c_nop) : '0;
    assign im_o_ack   = r_ack;
    assign im_o_last  = r_last;
    assign im_o_err   = r_err;
    assign im_o_busy  = r_busy;

endmodule : instr_mem_ctrl
`default_nettype wire
